// File: rtl/io_txport.sv
// Memory-mapped UART transmit port: a small write FIFO feeding an 8N1 shifter.
// Select is W with ADDR[15:12]==2; ADDR[0]=0 queues DOUT[7:0], ADDR[0]=1 clears Overflow.
module io_txport #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH        = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        W,
  input  logic [15:0] ADDR,
  input  logic [15:0] DOUT,
  output logic [15:0] STATUS,
  output logic        TxD,
  output logic        Busy
);

  // state | meaning
  // IDLE  | line high, pops the head byte as soon as the FIFO is non-empty
  // START | start bit (low) for one bit time
  // DATA  | eight data bits, LSB first, one bit time each
  // STOP  | stop bit (high) for one bit time

  localparam int              AW          = $clog2(DEPTH);
  localparam logic [15:0]     BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]     DEPTH_CNT   = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state, state_next;
  logic        sel, sel_push, sel_clear, push_ok, pop;
  logic [AW:0] wr_ptr, rd_ptr, occupancy;
  logic [7:0]  mem [DEPTH];
  logic [7:0]  head;
  logic        full, empty, overflow;
  logic [15:0] baud_cnt;
  logic        baud_done;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        txd_q, txd_next, busy_q;
  logic        unused_ok;

  assign sel       = W & (ADDR[15:12] == 4'h2);
  assign sel_push  = sel & ~ADDR[0];
  assign sel_clear = sel & ADDR[0];
  assign occupancy = wr_ptr - rd_ptr;
  assign full      = (occupancy == DEPTH_CNT);
  assign empty     = (wr_ptr == rd_ptr);
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign push_ok   = sel_push & (~full | pop);
  assign head      = mem[rd_ptr[AW-1:0]];
  assign baud_done = (baud_cnt == 16'd0);
  assign unused_ok = &{1'b0, DOUT[15:8], ADDR[11:1]};

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (sel_clear)
        overflow <= 1'b0;
      else if (sel_push && full && !pop)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= DOUT[7:0];
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      baud_cnt <= 16'd0;
      bit_idx  <= 3'd0;
      shift    <= 8'd0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state  <= state_next;
      txd_q  <= txd_next;
      busy_q <= (state != IDLE);
      case (state)
        IDLE: begin
          if (pop) begin
            shift    <= head;
            baud_cnt <= BAUD_RELOAD;
            bit_idx  <= 3'd0;
          end
        end
        START: baud_cnt <= baud_done ? BAUD_RELOAD : baud_cnt - 16'd1;
        DATA: begin
          baud_cnt <= baud_done ? BAUD_RELOAD : baud_cnt - 16'd1;
          if (baud_done) bit_idx <= bit_idx + 3'd1;
        end
        STOP: baud_cnt <= baud_done ? 16'd0 : baud_cnt - 16'd1;
        default: baud_cnt <= 16'd0;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!empty) state_next = START;
      START:   if (baud_done) state_next = DATA;
      DATA:    if (baud_done && bit_idx == 3'd7) state_next = STOP;
      STOP:    if (baud_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pop      = 1'b0;
    txd_next = 1'b1;
    case (state)
      IDLE:    pop = ~empty;
      START:   txd_next = 1'b0;
      DATA:    txd_next = shift[bit_idx];
      STOP:    txd_next = 1'b1;
      default: txd_next = 1'b1;
    endcase
  end

  // The line lags the state by one register stage; Busy stays up until the stop bit has left it.
  assign TxD    = txd_q;
  assign Busy   = (state != IDLE) | busy_q;
  assign STATUS = {11'b0, overflow, full, empty, Busy, TxD};

endmodule

// File: tb/tb_io_txport.sv
// Directed bench for io_txport with CLKS_PER_BIT=4, DEPTH=4.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_io_txport;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        W;
  logic [15:0] ADDR;
  logic [15:0] DOUT;
  logic [15:0] STATUS;
  logic        TxD;
  logic        Busy;

  int   checks = 0;
  int   errors = 0;
  logic tx_log [0:299];
  int   n_log;
  int   busy_cnt;

  io_txport #(.CLKS_PER_BIT(4), .DEPTH(4)) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .W      (W),
    .ADDR   (ADDR),
    .DOUT   (DOUT),
    .STATUS (STATUS),
    .TxD    (TxD),
    .Busy   (Busy)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic tick_log();
    tick();
    if (n_log < 300) begin
      tx_log[n_log] = TxD;
      n_log++;
    end
    if (Busy) busy_cnt++;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    W = 1'b1; ADDR = a; DOUT = d;
    tick();
    W = 1'b0;
  endtask

  // Expected line for one isolated frame, sample k taken after edge k (write accepted at edge 0).
  function automatic logic exp_tx(input int k, input logic [7:0] b);
    if (k < 2)  return 1'b1;
    if (k < 6)  return 1'b0;
    if (k < 38) return b[(k - 6) / 4];
    return 1'b1;
  endfunction

  // Finds frames in tx_log, checking bytes (incrementing from first_b), stop bits and spacing.
  task automatic decode(input logic [7:0] first_b, input int exp_frames, input int exp_first_fall);
    int k, frames, last;
    logic [7:0] b;
    frames = 0; last = -1; k = 1;
    while (k < n_log - 40) begin
      if (tx_log[k-1] == 1'b1 && tx_log[k] == 1'b0) begin
        for (int i = 0; i < 8; i++) b[i] = tx_log[k + 4*(i+1) + 1];
        check("frame_byte", b, 8'(first_b + frames));
        check("frame_stop", tx_log[k + 37], 1'b1);
        if (frames == 0) check("first_fall", k, exp_first_fall);
        else             check("pop_spacing", k - last, 41);
        last = k;
        frames++;
        k += 39;
      end else begin
        k++;
      end
    end
    check("frame_count", frames, exp_frames);
  endtask

  initial begin
    logic [59:0] got_v, exp_v;
    logic        saw_low;

    Reset = 1'b1; W = 1'b0; ADDR = 16'h0000; DOUT = 16'h0000;
    repeat (3) tick();
    check("reset_status", STATUS, 16'h0005);
    check("reset_txd", TxD, 1'b1);
    check("reset_busy", Busy, 1'b0);
    Reset = 1'b0;

    // Single frame 0xA5
    n_log = 0; busy_cnt = 0;
    W = 1'b1; ADDR = 16'h2000; DOUT = 16'h00A5;
    tick_log();
    W = 1'b0;
    check("a5_queued_status", STATUS, 16'h0001);
    tick_log();
    check("a5_popped_status", STATUS, 16'h0007);
    repeat (58) tick_log();
    for (int k = 0; k < 60; k++) begin
      got_v[k] = tx_log[k];
      exp_v[k] = exp_tx(k, 8'hA5);
    end
    check("a5_line", got_v, exp_v);
    check("a5_busy_cycles", busy_cnt, 41);
    decode(8'hA5, 1, 2);

    // Six back-to-back writes: 0x11 popped, 0x12..0x15 fill, 0x16 dropped
    n_log = 0; busy_cnt = 0;
    W = 1'b1; ADDR = 16'h2000;
    for (int i = 0; i < 6; i++) begin
      DOUT = 16'h0011 + 16'(i);
      tick_log();
      if (i == 4) check("burst_full", STATUS, 16'h000A);
    end
    W = 1'b0;
    check("burst_overflow", STATUS, 16'h001A);
    repeat (224) tick_log();
    decode(8'h11, 5, 2);
    check("burst_drained", STATUS, 16'h0015);

    // Overflow clear, nothing queued
    wr(16'h2001, 16'hFFFF);
    check("ovf_clear", STATUS, 16'h0005);
    repeat (3) tick();
    check("ovf_clear_no_push", STATUS, 16'h0005);

    // Writes outside the 0x2xxx window are ignored
    wr(16'h1000, 16'h0055);
    wr(16'h3000, 16'h0055);
    saw_low = 1'b0;
    repeat (10) begin
      tick();
      if (TxD !== 1'b1) saw_low = 1'b1;
    end
    check("foreign_txd_idle", saw_low, 1'b0);
    check("foreign_status", STATUS, 16'h0005);

    // Push into a full FIFO in the same cycle the shifter pops
    W = 1'b1; ADDR = 16'h2000;
    for (int i = 0; i < 5; i++) begin
      DOUT = 16'h0021 + 16'(i);
      tick();
    end
    W = 1'b0;
    check("popfull_full", STATUS, 16'h000A);
    repeat (37) tick();
    check("popfull_before", STATUS, 16'h000B);
    W = 1'b1; DOUT = 16'h0026;
    tick();
    check("popfull_accepted", STATUS, 16'h000B);
    DOUT = 16'h0027;
    tick();
    W = 1'b0;
    check("popfull_next_drops", STATUS, 16'h001A);

    // Write right after reset release, then reset during data bit 3 of 0x5A
    Reset = 1'b1;
    tick();
    check("reset2_status", STATUS, 16'h0005);
    Reset = 1'b0;
    wr(16'h2000, 16'h005A);
    repeat (17) tick();
    check("5a_bit2", TxD, 1'b0);
    tick();
    check("5a_bit3", TxD, 1'b1);
    check("5a_bit3_status", STATUS, 16'h0007);
    Reset = 1'b1;
    #1;
    check("abort_status", STATUS, 16'h0005);
    check("abort_busy", Busy, 1'b0);
    tick();
    Reset = 1'b0;
    saw_low = 1'b0;
    repeat (50) begin
      tick();
      if (TxD !== 1'b1) saw_low = 1'b1;
    end
    check("after_abort_idle", saw_low, 1'b0);
    check("after_abort_status", STATUS, 16'h0005);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
